spi_target: RTL and testbench



---
 rtl/spi_target_if.sv | 31 +++
 rtl/spi_target.sv | 205 ++++++++++++++++++++
 tb/tb_spi_target.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_if.sv
// Bus bundle for the SPI responder: the SPI pins plus the byte-level tx/rx handshakes.
// Reset and clock stay plain ports on the module.
interface spi_target_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_sclk;
   logic                  i_cs_n;
   logic                  i_mosi;
   logic                  o_miso;
   logic                  o_miso_oen;
   logic [DATA_WIDTH-1:0] i_tx_data;
   logic                  i_tx_valid;
   logic                  o_tx_ready;
   logic [DATA_WIDTH-1:0] o_rx_data;
   logic                  o_rx_valid;
   logic                  o_busy;
   logic                  o_frame_err;
   logic                  o_underrun;

   modport slave (
      input  i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
      output o_miso, o_miso_oen, o_tx_ready, o_rx_data, o_rx_valid,
             o_busy, o_frame_err, o_underrun
   );

   modport master (
      output i_sclk, i_cs_n, i_mosi, i_tx_data, i_tx_valid,
      input  o_miso, o_miso_oen, o_tx_ready, o_rx_data, o_rx_valid,
             o_busy, o_frame_err, o_underrun
   );
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 responder: synchronises sclk/cs_n/mosi into i_clk, shifts frames both ways,
// and exposes a one-deep tx holding register plus an rx valid pulse.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | cs_n high, MISO released, waiting for cs_n fall
// ST_ACTIVE | cs_n low, shifting on detected sclk edges, MISO driven
module spi_target #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   spi_target_if.slave bus
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_edge_q, sclk_edge_d;
   logic                   cs_edge_q, cs_edge_d;

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  tx_full_q, tx_full_d;
   logic                  reload_q, reload_d;
   logic                  miso_q, miso_d;
   logic                  oen_q, oen_d;
   logic                  busy_q, busy_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  underrun_q, underrun_d;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic do_load;
   logic [DATA_WIDTH-1:0] load_word, tx_shifted, rx_next;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_edge_q;
   assign sclk_fall = ~sclk_s &  sclk_edge_q;
   assign cs_rise   =  cs_s   & ~cs_edge_q;
   assign cs_fall   = ~cs_s   &  cs_edge_q;

   // An empty holding register loads all-zero and flags an underrun.
   assign load_word  = tx_full_q ? tx_hold_q : '0;
   assign tx_shifted = MSB_FIRST ? {tx_shift_q[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
   assign rx_next    = MSB_FIRST ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s}
                                 : {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.i_sclk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.i_cs_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.i_mosi};
      sclk_edge_d = sclk_s;
      cs_edge_d   = cs_s;

      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      tx_hold_d   = tx_hold_q;
      tx_full_d   = tx_full_q;
      rx_data_d   = rx_data_q;
      reload_d    = reload_q;
      miso_d      = miso_q;
      oen_d       = oen_q;
      busy_d      = busy_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;
      do_load     = 1'b0;

      if (bus.i_tx_valid && !tx_full_q) begin
         tx_hold_d = bus.i_tx_data;
         tx_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = '0;
               reload_d  = 1'b0;
               oen_d     = 1'b0;
               busy_d    = 1'b1;
               do_load   = 1'b1;
            end
         end
         default: begin
            if (cs_rise) begin
               state_d   = ST_IDLE;
               bit_cnt_d = '0;
               reload_d  = 1'b0;
               oen_d     = 1'b1;
               miso_d    = 1'b0;
               busy_d    = 1'b0;
               // A frame completed in the very cycle cs_n rose is still delivered.
               if (bit_cnt_q == CW'(DATA_WIDTH)) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end else if (bit_cnt_q != '0) begin
                  frame_err_d = 1'b1;
               end
            end else begin
               if (bit_cnt_q == CW'(DATA_WIDTH)) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
                  reload_d   = 1'b1;
               end else if (sclk_rise) begin
                  rx_shift_d = rx_next;
                  bit_cnt_d  = bit_cnt_q + CW'(1);
               end
               if (sclk_fall) begin
                  if (reload_q) begin
                     do_load  = 1'b1;
                     reload_d = 1'b0;
                  end else begin
                     tx_shift_d = tx_shifted;
                     miso_d     = first_bit(tx_shifted);
                  end
               end
            end
         end
      endcase

      if (do_load) begin
         tx_shift_d = load_word;
         miso_d     = first_bit(load_word);
         underrun_d = ~tx_full_q;
         if (tx_full_q) tx_full_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_edge_q <= 1'b0;
         cs_edge_q   <= 1'b1;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         tx_hold_q   <= '0;
         tx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         reload_q    <= 1'b0;
         miso_q      <= 1'b0;
         oen_q       <= 1'b1;
         busy_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_edge_q <= sclk_edge_d;
         cs_edge_q   <= cs_edge_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_hold_q   <= tx_hold_d;
         tx_full_q   <= tx_full_d;
         rx_data_q   <= rx_data_d;
         reload_q    <= reload_d;
         miso_q      <= miso_d;
         oen_q       <= oen_d;
         busy_q      <= busy_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.o_miso      = miso_q;
   assign bus.o_miso_oen  = oen_q;
   assign bus.o_tx_ready  = ~tx_full_q;
   assign bus.o_rx_data   = rx_data_q;
   assign bus.o_rx_valid  = rx_valid_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_frame_err = frame_err_q;
   assign bus.o_underrun  = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an MSB-first and an LSB-first responder share the SPI pins; a
// bit-banged master drives frames and results are checked against byte-level expectations.
module tb_spi_target;
   localparam int SYNC = 2;
   localparam int HP   = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;

   int tests = 0;
   int fails = 0;

   spi_target_if #(.DATA_WIDTH(8)) bus_m ();
   spi_target_if #(.DATA_WIDTH(8)) bus_l ();

   assign bus_m.i_sclk = sclk;
   assign bus_m.i_cs_n = cs_n;
   assign bus_m.i_mosi = mosi;
   assign bus_l.i_sclk = sclk;
   assign bus_l.i_cs_n = cs_n;
   assign bus_l.i_mosi = mosi;

   spi_target #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) u_msb (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_m));
   spi_target #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) u_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_l));

   always #5 clk = ~clk;

   logic [7:0] rxq[$];
   int ferr_cnt = 0;
   int unr_cnt = 0;
   int rx_l_cnt = 0;
   logic [7:0] rx_l_last = '0;

   always @(negedge clk) begin
      if (bus_m.o_rx_valid) rxq.push_back(bus_m.o_rx_data);
      if (bus_m.o_frame_err) ferr_cnt <= ferr_cnt + 1;
      if (bus_m.o_underrun) unr_cnt <= unr_cnt + 1;
      if (bus_l.o_rx_valid) begin
         rx_l_cnt  <= rx_l_cnt + 1;
         rx_l_last <= bus_l.o_rx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_tx(input bit to_l, input logic [7:0] d);
      @(negedge clk);
      if (to_l) begin bus_l.i_tx_data = d; bus_l.i_tx_valid = 1'b1; end
      else      begin bus_m.i_tx_data = d; bus_m.i_tx_valid = 1'b1; end
      @(negedge clk);
      bus_l.i_tx_valid = 1'b0;
      bus_m.i_tx_valid = 1'b0;
   endtask

   task automatic wait_ready_m();
      for (int k = 0; k < 20 && !bus_m.o_tx_ready; k++) tick(1);
      check("tx_ready_timeout", bus_m.o_tx_ready, 1'b1);
   endtask

   task automatic cs_low();
      @(negedge clk); cs_n = 1'b0; tick(HP);
   endtask

   task automatic cs_high();
      @(negedge clk); cs_n = 1'b1; tick(HP);
   endtask

   // Master side: n bits of mo, order chosen by lsb; MISO of both targets is sampled just
   // before each raw rising edge and assembled in that target's own bit order.
   task automatic send_bits(input logic [7:0] mo, input int n, input bit lsb, input bit chk_lat,
                            output logic [7:0] mi_m, output logic [7:0] mi_l);
      int b;
      int lat;
      mi_m = '0;
      mi_l = '0;
      for (int i = 0; i < n; i++) begin
         b = lsb ? i : 7 - i;
         mosi = mo[b];
         tick(HP);
         mi_m[7-i] = bus_m.o_miso;
         mi_l[i]   = bus_l.o_miso;
         sclk = 1'b1;
         if (chk_lat && i == n - 1) begin
            lat = -1;
            for (int k = 1; k <= HP; k++) begin
               @(negedge clk);
               if (bus_m.o_rx_valid && lat < 0) lat = k;
            end
            check("rx_valid_latency", lat, SYNC + 2);
         end else begin
            tick(HP);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic check_rx_m(input string tag, input int n0, input logic [7:0] exp);
      logic [7:0] got;
      check({tag, "_rx_count"}, rxq.size(), n0 + 1);
      got = (rxq.size() > n0) ? rxq[n0] : 8'hxx;
      check({tag, "_rx_data"}, got, exp);
      rxq.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, bus_m.o_busy, 1'b0);
      check({tag, "_oen"},  bus_m.o_miso_oen, 1'b1);
      check({tag, "_miso"}, bus_m.o_miso, 1'b0);
   endtask

   logic [7:0] mm, ml, tx_v, rx_v;
   int n0, u0, f0, l0;
   bit have;

   initial begin
      bus_m.i_tx_data = '0; bus_m.i_tx_valid = 1'b0;
      bus_l.i_tx_data = '0; bus_l.i_tx_valid = 1'b0;
      tick(3);
      check("rst_miso", bus_m.o_miso, 1'b0);
      check("rst_oen", bus_m.o_miso_oen, 1'b1);
      check("rst_ready", bus_m.o_tx_ready, 1'b1);
      check("rst_rx_data", bus_m.o_rx_data, 8'h00);
      check("rst_pulses", {bus_m.o_rx_valid, bus_m.o_busy, bus_m.o_frame_err, bus_m.o_underrun}, 4'b0);
      rst_n = 1'b1;
      tick(3);

      // 1: tx 0xA5, rx 0x3C
      write_tx(1'b0, 8'hA5);
      check("t1_ready_fell", bus_m.o_tx_ready, 1'b0);
      u0 = unr_cnt; rxq.delete();
      cs_low();
      check("t1_ready_after_load", bus_m.o_tx_ready, 1'b1);
      check("t1_busy", bus_m.o_busy, 1'b1);
      check("t1_oen", bus_m.o_miso_oen, 1'b0);
      check("t1_underrun", unr_cnt - u0, 0);
      send_bits(8'h3C, 8, 1'b0, 1'b1, mm, ml);
      check("t1_miso", mm, 8'hA5);
      check_rx_m("t1", 0, 8'h3C);
      cs_high();
      check_idle_outputs("t1_end");

      // 2: underrun frame
      u0 = unr_cnt;
      cs_low();
      check("t2_underrun", unr_cnt - u0, 1);
      send_bits(8'hFF, 8, 1'b0, 1'b0, mm, ml);
      check("t2_miso", mm, 8'h00);
      check_rx_m("t2", 0, 8'hFF);
      cs_high();

      // 3: back-to-back frames with cs_n held low
      write_tx(1'b0, 8'h12);
      cs_low();
      wait_ready_m();
      write_tx(1'b0, 8'h34);
      send_bits(8'hDE, 8, 1'b0, 1'b0, mm, ml);
      check("t3_miso0", mm, 8'h12);
      check_rx_m("t3a", 0, 8'hDE);
      send_bits(8'hAD, 8, 1'b0, 1'b0, mm, ml);
      check("t3_miso1", mm, 8'h34);
      check_rx_m("t3b", 0, 8'hAD);
      cs_high();

      // 4: aborted frame after 5 bits, then a clean frame
      f0 = ferr_cnt;
      cs_low();
      send_bits(8'hF0, 5, 1'b0, 1'b0, mm, ml);
      cs_high();
      check("t4_frame_err", ferr_cnt - f0, 1);
      check("t4_no_rx", rxq.size(), 0);
      check_idle_outputs("t4_abort");
      cs_low();
      send_bits(8'h81, 8, 1'b0, 1'b0, mm, ml);
      check_rx_m("t4", 0, 8'h81);
      cs_high();
      check("t4_frame_err_once", ferr_cnt - f0, 1);

      // 5: reset mid-frame with the holding register full
      write_tx(1'b0, 8'h77);
      cs_low();
      wait_ready_m();
      write_tx(1'b0, 8'h66);
      check("t5_hold_full", bus_m.o_tx_ready, 1'b0);
      send_bits(8'h00, 3, 1'b0, 1'b0, mm, ml);
      rst_n = 1'b0;
      #1;
      check("t5_rst_outputs",
            {bus_m.o_miso, bus_m.o_miso_oen, bus_m.o_tx_ready, bus_m.o_rx_valid,
             bus_m.o_busy, bus_m.o_frame_err, bus_m.o_underrun}, 7'b0110000);
      check("t5_rst_rx_data", bus_m.o_rx_data, 8'h00);
      cs_n = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      rxq.delete();
      write_tx(1'b0, 8'h5A);
      cs_low();
      send_bits(8'hC3, 8, 1'b0, 1'b0, mm, ml);
      check("t5_miso", mm, 8'h5A);
      check_rx_m("t5", 0, 8'hC3);
      cs_high();

      // Random frames against the byte-level model
      for (int f = 0; f < 8; f++) begin
         have = 1'($urandom_range(0, 1));
         tx_v = 8'($urandom);
         rx_v = 8'($urandom);
         if (have) write_tx(1'b0, tx_v);
         u0 = unr_cnt;
         cs_low();
         check("rnd_underrun", unr_cnt - u0, have ? 0 : 1);
         send_bits(rx_v, 8, 1'b0, 1'b0, mm, ml);
         check("rnd_miso", mm, have ? tx_v : 8'h00);
         check_rx_m("rnd", 0, rx_v);
         cs_high();
      end

      // 6: LSB-first target
      l0 = rx_l_cnt;
      write_tx(1'b1, 8'h01);
      cs_low();
      send_bits(8'h80, 8, 1'b1, 1'b0, mm, ml);
      check("t6_first_bit", ml[0], 1'b1);
      check("t6_miso", ml, 8'h01);
      cs_high();
      check("t6_rx_count", rx_l_cnt - l0, 1);
      check("t6_rx_data", rx_l_last, 8'h80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
      $fatal(1, "watchdog");
   end
endmodule
